// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu: RV64 load/store unit between execute and writeback.
// Ports: clk, rst (async, active-high)
//        exu_valid_i/lsu_ready_o, rd_wr_en_i, rd_idx_i, alu_res_i, ls_info_bus_i, rs2_store_i - op from execute
//        mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wmask_o, mem_gnt_i, mem_rvalid_i/mem_rdata_i - data memory
//        wb_valid_o, wb_rd_wr_en_o, wb_rd_idx_o, wb_data_o - one-cycle writeback beat
//        misalign_o - misaligned-access pulse
// Optional: define YSYX_22040237_LSU_MISALIGN_CHK_EN to trap size-misaligned accesses without a memory request.
module ysyx_22040237_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid_i,
  output logic              lsu_ready_o,
  input  logic              rd_wr_en_i,
  input  logic [4:0]        rd_idx_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [6:0]        ls_info_bus_i,
  input  logic [DATA_W-1:0] rs2_store_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_rd_wr_en_o,
  output logic [4:0]        wb_rd_idx_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  state_t            state_q;
  logic              ready_q, mem_req_q, mem_we_q, wb_valid_q, wb_wen_q, misalign_q;
  logic              ld_q, usign_q, wen_q;
  logic [1:0]        sz_q;
  logic [2:0]        off_q;
  logic [4:0]        wb_idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, wb_data_q;
  logic [7:0]        mem_wmask_q;
  logic              ld_i, is_ls_i, mis_i;
  logic [1:0]        sz_i;
  logic [2:0]        off_i;
  logic [7:0]        wmask_i;
  logic [DATA_W-1:0] wdata_i, sh, ld_data;
  // load wins when both load and store are set; size code 0..3 = byte..dw, dw when no size bit
  assign ld_i    = ls_info_bus_i[0];
  assign is_ls_i = |ls_info_bus_i[1:0];
  assign sz_i    = ls_info_bus_i[6] ? 2'd3 : ls_info_bus_i[5] ? 2'd2 :
                   ls_info_bus_i[4] ? 2'd1 : ls_info_bus_i[3] ? 2'd0 : 2'd3;
  assign off_i   = alu_res_i[2:0];
  // lanes past byte 7 fall off the shift: boundary-crossing accesses are truncated, never split
  assign wmask_i = (sz_i == 2'd0 ? 8'h01 : sz_i == 2'd1 ? 8'h03 : sz_i == 2'd2 ? 8'h0f : 8'hff) << off_i;
  assign wdata_i = rs2_store_i << {off_i, 3'b000};
`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
  assign mis_i = is_ls_i & (sz_i == 2'd1 ? off_i[0] : sz_i == 2'd2 ? |off_i[1:0] : sz_i == 2'd3 ? |off_i : 1'b0);
`else
  assign mis_i = 1'b0;
`endif
  assign sh      = mem_rdata_i >> {off_q, 3'b000};
  assign ld_data = sz_q == 2'd3 ? sh :
                   sz_q == 2'd2 ? {{32{~usign_q & sh[31]}}, sh[31:0]} :
                   sz_q == 2'd1 ? {{48{~usign_q & sh[15]}}, sh[15:0]} :
                                  {{56{~usign_q & sh[7]}}, sh[7:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_idx_q    <= '0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      ld_q        <= 1'b0;
      usign_q     <= 1'b0;
      wen_q       <= 1'b0;
      sz_q        <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (exu_valid_i) begin
          ready_q  <= 1'b0;
          wb_idx_q <= rd_idx_i;
          wen_q    <= rd_wr_en_i;
          ld_q     <= ld_i;
          usign_q  <= ls_info_bus_i[2];
          sz_q     <= sz_i;
          off_q    <= off_i;
          if (!is_ls_i || mis_i) begin
            state_q    <= RESP;
            wb_valid_q <= 1'b1;
            wb_wen_q   <= ~is_ls_i & rd_wr_en_i;
            wb_data_q  <= is_ls_i ? '0 : alu_res_i;
            misalign_q <= mis_i;
          end else begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ~ld_i;
            mem_addr_q  <= ADDR_W'({alu_res_i[DATA_W-1:3], 3'b000});
            mem_wdata_q <= ld_i ? '0 : wdata_i;
            mem_wmask_q <= ld_i ? '0 : wmask_i;
          end
        end
        REQ: if (mem_gnt_i) begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          mem_wmask_q <= '0;
          if (ld_q) state_q <= WAIT_R;
          else begin
            state_q    <= RESP;
            wb_valid_q <= 1'b1;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= '0;
          end
        end
        WAIT_R: if (mem_rvalid_i) begin
          state_q    <= RESP;
          wb_valid_q <= 1'b1;
          wb_wen_q   <= wen_q;
          wb_data_q  <= ld_data;
        end
        RESP: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          wb_valid_q <= 1'b0;
          misalign_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign lsu_ready_o   = ready_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_wmask_o   = mem_wmask_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_wr_en_o = wb_wen_q;
  assign wb_rd_idx_o   = wb_idx_q;
  assign wb_data_o     = wb_data_q;
  assign misalign_o    = misalign_q;
endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu: directed table, corner sequences and random ops against a byte-level model.
module tb_ysyx_22040237_lsu;
  logic        clk, rst, exu_valid, rd_wr_en, mem_gnt, mem_rvalid;
  logic [4:0]  rd_idx;
  logic [63:0] alu_res, rs2, mem_rdata;
  logic [6:0]  ls_info;
  logic        lsu_ready, mem_req, mem_we, wb_valid, wb_wen, misalign;
  logic [63:0] mem_addr, mem_wdata, wb_data;
  logic [7:0]  mem_wmask;
  logic [4:0]  wb_idx;
  int n_cmp = 0, n_bad = 0;

  ysyx_22040237_lsu dut (
    .clk(clk), .rst(rst), .exu_valid_i(exu_valid), .lsu_ready_o(lsu_ready),
    .rd_wr_en_i(rd_wr_en), .rd_idx_i(rd_idx), .alu_res_i(alu_res), .ls_info_bus_i(ls_info),
    .rs2_store_i(rs2), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid),
    .wb_rd_wr_en_o(wb_wen), .wb_rd_idx_o(wb_idx), .wb_data_o(wb_data), .misalign_o(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a; logic [6:0] ls; logic [63:0] d; logic [4:0] rd; logic we;
    int gd; int rvd; logic [63:0] rdata; logic [63:0] e_data; logic [7:0] e_mask; logic [63:0] e_wdata;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, want %h", nm, f, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [6:0] ls);
    return ls[6] ? 8 : ls[5] ? 4 : ls[4] ? 2 : ls[3] ? 1 : 8;
  endfunction

  function automatic logic m_mis(input logic [63:0] a, input logic [6:0] ls);
`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
    int n = nbytes(ls);
    return (ls[0] | ls[1]) && (int'(a[2:0]) % n != 0);
`else
    return (a[0] & ls[0] & ls[1] & 1'b0);
`endif
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] a, input logic [6:0] ls);
    logic [63:0] v = '0;
    int n = nbytes(ls), off = int'(a[2:0]);
    for (int k = 0; k < n; k++) if (off + k < 8) v[8*k +: 8] = rdata[8*(off+k) +: 8];
    if (!ls[2] && n < 8 && v[8*n-1]) for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [63:0] a, input logic [6:0] ls);
    logic [7:0] m = '0;
    int n = nbytes(ls), off = int'(a[2:0]);
    for (int k = 0; k < n; k++) if (off + k < 8) m[off+k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] d);
    logic [63:0] w = '0;
    int off = int'(a[2:0]);
    for (int k = off; k < 8; k++) w[8*k +: 8] = d[8*(k-off) +: 8];
    return w;
  endfunction

  task automatic do_op(input logic [63:0] a, input logic [6:0] ls, input logic [63:0] d, input logic [4:0] rd,
                       input logic we, input int gd, input int rvd, input logic [63:0] rdata,
                       input logic [63:0] e_data, input logic [7:0] e_mask, input logic [63:0] e_wdata,
                       input string nm);
    logic ld, st, mis;
    ld = ls[0];
    st = ls[1] & ~ls[0];
    mis = m_mis(a, ls);
    chk(nm, "ready_idle", lsu_ready, 1);
    exu_valid = 1'b1; alu_res = a; ls_info = ls; rs2 = d; rd_idx = rd; rd_wr_en = we;
    tick();
    exu_valid = 1'b0;
    chk(nm, "ready_busy", lsu_ready, 0);
    if (mis || !(ld || st)) begin
      chk(nm, "req", mem_req, 0);
      chk(nm, "wb_valid", wb_valid, 1);
      chk(nm, "wb_data", wb_data, mis ? 64'h0 : e_data);
      chk(nm, "wb_wen", wb_wen, mis ? 1'b0 : we);
      chk(nm, "misalign", misalign, mis);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        chk(nm, "req", mem_req, 1);
        chk(nm, "we", mem_we, st);
        chk(nm, "addr", mem_addr, {a[63:3], 3'b000});
        if (st) begin
          chk(nm, "wmask", mem_wmask, e_mask);
          chk(nm, "wdata", mem_wdata, e_wdata);
        end
        chk(nm, "wb_early", wb_valid, 0);
        mem_gnt = (i == gd);
        tick();
      end
      mem_gnt = 1'b0;
      chk(nm, "req_drop", mem_req, 0);
      if (ld) begin
        for (int i = 0; i < rvd; i++) begin
          chk(nm, "wb_wait", wb_valid, 0);
          tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
        chk(nm, "wb_data", wb_data, e_data);
        chk(nm, "wb_wen", wb_wen, we);
      end else chk(nm, "wb_wen", wb_wen, 0);
      chk(nm, "wb_valid", wb_valid, 1);
      chk(nm, "misalign", misalign, 0);
    end
    chk(nm, "wb_idx", wb_idx, rd);
    tick();
    chk(nm, "wb_pulse", wb_valid, 0);
    chk(nm, "ready_back", lsu_ready, 1);
  endtask

  initial begin
    tv[0]  = '{64'h1234, 7'h00, 64'h0, 5'd5, 1'b1, 0, 0, 64'h0, 64'h1234, 8'h0, 64'h0};
    tv[1]  = '{64'h8000_0003, 7'h0A, 64'hAB, 5'd7, 1'b1, 3, 0, 64'h0, 64'h0, 8'h08, 64'hAB00_0000};
    tv[2]  = '{64'h8000_0006, 7'h11, 64'h0, 5'd8, 1'b1, 0, 0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h0, 64'h0};
    tv[3]  = '{64'h8000_0006, 7'h15, 64'h0, 5'd8, 1'b1, 1, 1, 64'h8001_0000_0000_0000, 64'h8001, 8'h0, 64'h0};
    tv[4]  = '{64'h8000_0104, 7'h21, 64'h0, 5'd9, 1'b1, 1, 5, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0, 64'h0};
    tv[5]  = '{64'h100, 7'h42, 64'h1122_3344_5566_7788, 5'd1, 1'b1, 0, 0, 64'h0, 64'h0, 8'hFF, 64'h1122_3344_5566_7788};
    tv[6]  = '{64'h206, 7'h22, 64'hAABB_CCDD, 5'd2, 1'b1, 1, 0, 64'h0, 64'h0, 8'hC0, 64'hCCDD_0000_0000_0000};
    tv[7]  = '{64'h307, 7'h09, 64'h0, 5'd3, 1'b1, 0, 2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h0, 64'h0};
    tv[8]  = '{64'h10, 7'h43, 64'h5555, 5'd4, 1'b1, 2, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h0, 64'h0};
    tv[9]  = '{64'h8, 7'h05, 64'h0, 5'd6, 1'b0, 0, 0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 8'h0, 64'h0};
    tv[10] = '{64'h406, 7'h21, 64'h0, 5'd10, 1'b1, 0, 0, 64'hBEEF_0000_0000_0000, 64'hBEEF, 8'h0, 64'h0};
    tv[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'h04, 64'h0, 5'd31, 1'b0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0, 64'h0};
    tv[12] = '{64'h502, 7'h12, 64'hFFFF_1234, 5'd11, 1'b1, 2, 0, 64'h0, 64'h0, 8'h0C, 64'h0000_FFFF_1234_0000};
    rst = 1'b0; exu_valid = 1'b0; rd_wr_en = 1'b0; rd_idx = '0; alu_res = '0; ls_info = '0; rs2 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset", "ready", lsu_ready, 1);
    chk("reset", "req", mem_req, 0);
    chk("reset", "wb_valid", wb_valid, 0);
    chk("reset", "wb_data", wb_data, 0);
    chk("reset", "misalign", misalign, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    foreach (tv[i])
      do_op(tv[i].a, tv[i].ls, tv[i].d, tv[i].rd, tv[i].we, tv[i].gd, tv[i].rvd, tv[i].rdata,
            tv[i].e_data, tv[i].e_mask, tv[i].e_wdata, $sformatf("vec%0d", i));

    // rvalid outside WAIT_R (idle, and together with gnt) must be ignored
    mem_rvalid = 1'b1; mem_rdata = 64'h7F;
    tick();
    chk("rv_idle", "wb_valid", wb_valid, 0);
    mem_rvalid = 1'b0;
    exu_valid = 1'b1; alu_res = 64'h0; ls_info = 7'h09; rd_idx = 5'd12; rd_wr_en = 1'b1;
    tick();
    exu_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h7F;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("rv_gnt", "wb_valid0", wb_valid, 0);
    tick();
    chk("rv_gnt", "wb_valid1", wb_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h81;
    tick();
    mem_rvalid = 1'b0;
    chk("rv_gnt", "wb_valid2", wb_valid, 1);
    chk("rv_gnt", "wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF81);
    tick();

    // exu_valid while busy is not accepted
    exu_valid = 1'b1; alu_res = 64'h180; ls_info = 7'h42; rs2 = 64'h1; rd_idx = 5'd13;
    tick();
    ls_info = 7'h00; alu_res = 64'h99;
    tick();
    chk("busy", "ready", lsu_ready, 0);
    chk("busy", "req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; exu_valid = 1'b0;
    chk("busy", "wb_valid", wb_valid, 1);
    tick();
    chk("busy", "wb_after", wb_valid, 0);
    chk("busy", "ready_after", lsu_ready, 1);
    tick();
    chk("busy", "no_extra", wb_valid, 0);

    // async reset in REQ drops the request before any clock edge
    exu_valid = 1'b1; alu_res = 64'h80; ls_info = 7'h42; rs2 = 64'hFF;
    tick();
    exu_valid = 1'b0;
    chk("rst_req", "req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_req", "req", mem_req, 0);
    chk("rst_req", "wmask", mem_wmask, 0);
    chk("rst_req", "ready", lsu_ready, 1);
    tick();
    rst = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst_req", "wb_valid", wb_valid, 0);

    // async reset in WAIT_R, then a late rvalid
    exu_valid = 1'b1; alu_res = 64'h40; ls_info = 7'h21; rd_idx = 5'd14;
    tick();
    exu_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst_wait", "ready_before", lsu_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_wait", "ready", lsu_ready, 1);
    chk("rst_wait", "wb_valid", wb_valid, 0);
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_wait", "late_rv", wb_valid, 0);
    tick();
    chk("rst_wait", "late_rv2", wb_valid, 0);
    chk("rst_wait", "ready_end", lsu_ready, 1);

    for (int i = 0; i < 200; i++) begin
      logic [63:0] a, d, rdata, e;
      logic [6:0]  ls;
      a = {$urandom, $urandom}; d = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      ls = 7'($urandom_range(0, 127));
      e = (ls[0] | ls[1]) ? m_load(rdata, a, ls) : a;
      do_op(a, ls, d, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), rdata, e, m_mask(a, ls), m_wdata(a, d), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
